// File: rtl/rt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rt_pkg                                                       |
// | Description : Ray-tracer shared types (float, vector, ray) and frame size. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package rt_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int NUM_RAYS = SCREEN_W * SCREEN_H;

   typedef logic [31:0] float_t;

   typedef struct packed {
      float_t x;
      float_t y;
      float_t z;
   } vector_t;

   typedef struct packed {
      logic [31:0] ray_id;
      vector_t     origin;
      vector_t     dir;
   } ray_t;

endpackage
`default_nettype wire

// File: rtl/prg_ray_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prg_ray_queue_if                                             |
// | Description : Ray write/read handshake and status bundle of the ray queue. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface prg_ray_queue_if
   import rt_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int NUM_RAYS = rt_pkg::NUM_RAYS
) ();

   localparam int CW = $clog2(DEPTH + 1);
   localparam int RW = $clog2(NUM_RAYS + 1);

   logic          frame_start;
   logic          ray_ready;
   ray_t          ray_in;
   logic          out_valid;
   ray_t          out_ray;
   logic          out_ready;
   logic [CW-1:0] count;
   logic          almost_full;
   logic          overflow;
   logic [RW-1:0] rays_out;
   logic          frame_active;
   logic          frame_done;

   modport master (
      output frame_start, ray_ready, ray_in, out_ready,
      input  out_valid, out_ray, count, almost_full, overflow,
             rays_out, frame_active, frame_done
   );

   modport slave (
      input  frame_start, ray_ready, ray_in, out_ready,
      output out_valid, out_ray, count, almost_full, overflow,
             rays_out, frame_active, frame_done
   );

endinterface
`default_nettype wire

// File: rtl/prg_ray_queue_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_fifo                                                    |
// | Description : Generic first-word-fall-through FIFO, occupancy-based flags. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  wire logic                         clk,
   input  wire logic                         rst,
   input  wire logic                         wr_en,
   input  wire logic [WIDTH-1:0]             wr_data,
   input  wire logic                         rd_en,
   output logic      [WIDTH-1:0]             rd_data,
   output logic      [$clog2(DEPTH+1)-1:0]   count,
   output logic                              full,
   output logic                              empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
   assign empty  = (r_count == '0);
   assign full   = (r_count == C_FULL);
   assign w_pop  = rd_en & ~empty;
   assign w_push = wr_en & (~full | w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_data;
   end

   assign rd_data = r_mem[r_rd_ptr];
   assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/prg_ray_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prg_ray_queue                                                |
// | Description : Ray FIFO between prg and traversal with per-frame counting.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prg_ray_queue
   import rt_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int AF_MARGIN = 4,
   parameter int NUM_RAYS  = rt_pkg::NUM_RAYS
) (
   input  wire logic        clk,
   input  wire logic        rst,
   prg_ray_queue_if.slave   bus
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int RW = $clog2(NUM_RAYS + 1);
   localparam logic [CW-1:0] C_AF_LEVEL = CW'(DEPTH - AF_MARGIN);
   localparam logic [RW-1:0] C_LAST     = RW'(NUM_RAYS - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [RW-1:0] r_rays_out;
   logic [RW-1:0] w_rays_out_nxt;
   logic          r_overflow;
   logic [CW-1:0] w_count;
   logic          w_full;
   logic          w_empty;
   logic          w_hs;

   sync_fifo #(
      .WIDTH ($bits(ray_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bus.ray_ready),
      .wr_data (bus.ray_in),
      .rd_en   (bus.out_ready),
      .rd_data (bus.out_ray),
      .count   (w_count),
      .full    (w_full),
      .empty   (w_empty)
   );

   assign w_hs = ~w_empty & bus.out_ready;

   // Drop only happens when full with no simultaneous pop to make room.
   always_ff @(posedge clk) begin
      if (rst)                                 r_overflow <= 1'b0;
      else if (bus.ray_ready & w_full & ~w_hs) r_overflow <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_rays_out <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rays_out <= w_rays_out_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_rays_out_nxt = r_rays_out;
      case (r_state)
         ST_IDLE: begin
            if (bus.frame_start) begin
               w_state_nxt    = ST_ACTIVE;
               w_rays_out_nxt = '0;
            end
         end
         ST_ACTIVE: begin
            if (bus.frame_start) begin
               w_rays_out_nxt = '0;
            end else if (w_hs) begin
               w_rays_out_nxt = r_rays_out + RW'(1);
               if (r_rays_out == C_LAST) w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.frame_start) begin
               w_state_nxt    = ST_ACTIVE;
               w_rays_out_nxt = '0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt    = ST_IDLE;
            w_rays_out_nxt = '0;
         end
      endcase
   end

   assign bus.out_valid    = ~w_empty;
   assign bus.count        = w_count;
   assign bus.almost_full  = (w_count >= C_AF_LEVEL);
   assign bus.overflow     = r_overflow;
   assign bus.rays_out     = r_rays_out;
   assign bus.frame_active = (r_state == ST_ACTIVE);
   assign bus.frame_done   = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_prg_ray_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_prg_ray_queue                                             |
// | Description : Directed self-checking bench for prg_ray_queue.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_prg_ray_queue;
   import rt_pkg::*;

   localparam int DEPTH = 16;
   localparam int AF    = 4;
   localparam int NR    = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   exp_cnt;

   prg_ray_queue_if #(.DEPTH(DEPTH), .NUM_RAYS(NR)) bus ();

   prg_ray_queue #(
      .DEPTH     (DEPTH),
      .AF_MARGIN (AF),
      .NUM_RAYS  (NR)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic ray_t mk(input int id);
      ray_t r;
      r.ray_id   = 32'(id);
      r.origin.x = 32'(id * 3 + 1);
      r.origin.y = 32'(id * 5 + 2);
      r.origin.z = 32'(id * 7 + 3);
      r.dir.x    = 32'(id ^ 32'h0f0f);
      r.dir.y    = 32'(id + 32'h1000);
      r.dir.z    = 32'(32'hffff - id);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      bus.frame_start = 1'b0;
      bus.ray_ready   = 1'b0;
      bus.ray_in      = '0;
      bus.out_ready   = 1'b0;

      // Reset held for two cycles
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("rst_count", bus.count, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_af", bus.almost_full, 0);
      chk("rst_ovf", bus.overflow, 0);
      chk("rst_rays_out", bus.rays_out, 0);
      chk("rst_active", bus.frame_active, 0);
      chk("rst_done", bus.frame_done, 0);

      // Ordering, one write every third cycle with consumer always ready
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.ray_ready = 1'b1;
         bus.ray_in    = mk(i);
         step();
         bus.ray_ready = 1'b0;
         chk("ord_valid", bus.out_valid, 1);
         chk("ord_ray", bus.out_ray, mk(i));
         chk("ord_count", bus.count, 1);
         step();
         chk("ord_popped_valid", bus.out_valid, 0);
         chk("ord_popped_count", bus.count, 0);
         step();
      end
      bus.out_ready = 1'b0;

      // Fill to full, 17th write dropped
      for (int i = 0; i < 17; i++) begin
         bus.ray_ready = 1'b1;
         bus.ray_in    = mk(i);
         step();
         exp_cnt = (i < 16) ? i + 1 : 16;
         chk("fill_count", bus.count, exp_cnt);
         chk("fill_af", bus.almost_full, (exp_cnt >= 12) ? 1 : 0);
         chk("fill_ovf", bus.overflow, (i == 16) ? 1 : 0);
      end
      bus.ray_ready = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("drain_valid", bus.out_valid, 1);
         chk("drain_id", bus.out_ray.ray_id, i);
         step();
      end
      bus.out_ready = 1'b0;
      chk("drain_empty", bus.out_valid, 0);
      chk("drain_count", bus.count, 0);
      chk("drain_ovf_sticky", bus.overflow, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("ovf_cleared", bus.overflow, 0);

      // Push and pop together while full
      for (int i = 0; i < 16; i++) begin
         bus.ray_ready = 1'b1;
         bus.ray_in    = mk(100 + i);
         step();
      end
      chk("pp_full_count", bus.count, 16);
      bus.ray_ready = 1'b1;
      bus.ray_in    = mk(200);
      bus.out_ready = 1'b1;
      step();
      bus.ray_ready = 1'b0;
      chk("pp_count", bus.count, 16);
      chk("pp_ovf", bus.overflow, 0);
      for (int i = 0; i < 16; i++) begin
         chk("pp_drain_id", bus.out_ray.ray_id, (i < 15) ? 101 + i : 200);
         step();
      end
      bus.out_ready = 1'b0;
      chk("pp_empty", bus.out_valid, 0);

      // Frame of 8 rays plus one extra handshake afterwards
      for (int i = 0; i < 9; i++) begin
         bus.ray_ready = 1'b1;
         bus.ray_in    = mk(i);
         step();
      end
      bus.ray_ready   = 1'b0;
      bus.frame_start = 1'b1;
      step();
      bus.frame_start = 1'b0;
      chk("fr_active", bus.frame_active, 1);
      chk("fr_rays0", bus.rays_out, 0);
      bus.out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("fr_rays_out", bus.rays_out, k);
         if (k < 8) chk("fr_done_early", bus.frame_done, 0);
      end
      bus.out_ready = 1'b0;
      chk("fr_done", bus.frame_done, 1);
      chk("fr_inactive", bus.frame_active, 0);
      step();
      chk("fr_done_pulse", bus.frame_done, 0);
      chk("fr_idle", bus.frame_active, 0);
      chk("fr_hold", bus.rays_out, 8);
      chk("fr_left", bus.count, 1);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("fr_idle_hs", bus.rays_out, 8);
      chk("fr_idle_pop", bus.count, 0);

      // Reset in the middle of operation
      for (int i = 0; i < 5; i++) begin
         bus.ray_ready = 1'b1;
         bus.ray_in    = mk(50 + i);
         step();
      end
      bus.ray_ready = 1'b0;
      chk("mid_count", bus.count, 5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_valid", bus.out_valid, 0);
      chk("mid_count0", bus.count, 0);
      chk("mid_ovf", bus.overflow, 0);
      bus.ray_ready = 1'b1;
      bus.ray_in    = mk(42);
      step();
      bus.ray_ready = 1'b0;
      chk("mid_wr_valid", bus.out_valid, 1);
      chk("mid_wr_ray", bus.out_ray, mk(42));
      chk("mid_wr_count", bus.count, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
